// File: rtl/ref_sched_pkg.sv
// Shared types and constants for the reference-bank ping-pong scheduler.
package ref_sched_pkg;

    typedef enum logic [1:0] {
        L_IDLE  = 2'b00,
        L_WRITE = 2'b01,
        L_DRAIN = 2'b10,
        L_PEND  = 2'b11
    } load_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/ref_loader.sv
// Coefficient loader: writes one FRAME_LEN sequence into the inactive bank,
// flags bad lengths and holds the sequence until the top level swaps banks.
module ref_loader
    import ref_sched_pkg::*;
#(
    parameter int BRAM_DEPTH_BITS = 10,
    parameter int C_DATA_WIDTH    = 64,
    parameter int FRAME_LEN       = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [C_DATA_WIDTH-1:0]   tdata,
    input  logic                      tvalid,
    input  logic                      tlast,
    output logic                      tready,
    input  logic                      active_bank,
    input  logic                      swap,
    output logic                      we,
    output logic [BRAM_DEPTH_BITS:0]  waddr,
    output logic [C_DATA_WIDTH-1:0]   wdata,
    output logic                      err,
    output load_state_t               state
);

    localparam logic [BRAM_DEPTH_BITS-1:0] LAST_IDX = BRAM_DEPTH_BITS'(FRAME_LEN - 1);

    load_state_t                state_q, state_d;
    logic [BRAM_DEPTH_BITS-1:0] wptr_q;
    logic                       beat, at_last, write_en, ready_d;

    assign beat    = tvalid & tready;
    assign at_last = (wptr_q == LAST_IDX);
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= L_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE, L_WRITE: begin
                if (beat) begin
                    if (tlast) state_d = at_last ? L_PEND : L_IDLE;
                    else       state_d = at_last ? L_DRAIN : L_WRITE;
                end
            end
            L_DRAIN: if (beat && tlast) state_d = L_IDLE;
            L_PEND:  if (swap)          state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
    end

    always_comb begin
        write_en = beat && (state_q == L_IDLE || state_q == L_WRITE);
        ready_d  = (state_d != L_PEND);
    end

    // Ready is registered so it stays low throughout reset and rises one cycle after.
    // wptr returns to 0 at any sequence end; a pending sequence never advances it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready <= 1'b0;
            wptr_q <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            err    <= 1'b0;
        end else begin
            tready <= ready_d;
            we     <= write_en;
            if (write_en) begin
                waddr  <= {~active_bank, wptr_q};
                wdata  <= tdata;
                wptr_q <= (tlast || at_last) ? '0 : wptr_q + BRAM_DEPTH_BITS'(1);
                if (tlast ? !at_last : at_last) err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ref_bank_scheduler.sv
// Ping-pong reference BRAM controller: correlator read addressing, frame
// counting and frame-boundary bank swaps around the coefficient loader.
module ref_bank_scheduler
    import ref_sched_pkg::*;
#(
    parameter int BRAM_DEPTH_BITS = 10,
    parameter int C_DATA_WIDTH    = 64,
    parameter int FRAME_LEN       = 1024
) (
    input  logic                      S_AXIS_ACLK,
    input  logic                      S_AXIS_ARESETN,
    input  logic [C_DATA_WIDTH-1:0]   LOAD_TDATA,
    input  logic                      LOAD_TVALID,
    input  logic                      LOAD_TLAST,
    output logic                      LOAD_TREADY,
    input  logic                      FFT_TVALID,
    input  logic                      FFT_TREADY,
    input  logic                      FFT_TLAST,
    output logic                      BRAM_WE,
    output logic [BRAM_DEPTH_BITS:0]  BRAM_WADDR,
    output logic [C_DATA_WIDTH-1:0]   BRAM_WDATA,
    output logic [BRAM_DEPTH_BITS:0]  BRAM_RADDR,
    output logic                      ACTIVE_BANK,
    output logic                      SWAP_PENDING,
    output logic                      LOAD_ERR,
    output logic [FRAME_CNT_W-1:0]    FRAME_CNT
);

    localparam logic [BRAM_DEPTH_BITS-1:0] LAST_IDX = BRAM_DEPTH_BITS'(FRAME_LEN - 1);

    load_state_t                load_state;
    logic [BRAM_DEPTH_BITS-1:0] rptr_q;
    logic                       fft_beat, boundary, swap;

    ref_loader #(
        .BRAM_DEPTH_BITS (BRAM_DEPTH_BITS),
        .C_DATA_WIDTH    (C_DATA_WIDTH),
        .FRAME_LEN       (FRAME_LEN)
    ) u_loader (
        .clk         (S_AXIS_ACLK),
        .rst_n       (S_AXIS_ARESETN),
        .tdata       (LOAD_TDATA),
        .tvalid      (LOAD_TVALID),
        .tlast       (LOAD_TLAST),
        .tready      (LOAD_TREADY),
        .active_bank (ACTIVE_BANK),
        .swap        (swap),
        .we          (BRAM_WE),
        .waddr       (BRAM_WADDR),
        .wdata       (BRAM_WDATA),
        .err         (LOAD_ERR),
        .state       (load_state)
    );

    assign SWAP_PENDING = (load_state == L_PEND);
    assign fft_beat     = FFT_TVALID & FFT_TREADY;
    assign boundary     = fft_beat & (FFT_TLAST | (rptr_q == LAST_IDX));

    // Swap only between frames: on the closing beat, or while the reader idles at rptr 0.
    assign swap = SWAP_PENDING & (boundary | ((rptr_q == '0) & ~fft_beat));

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            rptr_q      <= '0;
            ACTIVE_BANK <= 1'b0;
            BRAM_RADDR  <= '0;
            FRAME_CNT   <= '0;
        end else begin
            if (boundary)      rptr_q <= '0;
            else if (fft_beat) rptr_q <= rptr_q + BRAM_DEPTH_BITS'(1);
            if (swap)     ACTIVE_BANK <= ~ACTIVE_BANK;
            if (boundary) FRAME_CNT   <= FRAME_CNT + FRAME_CNT_W'(1);
            BRAM_RADDR <= {ACTIVE_BANK, rptr_q};
        end
    end

endmodule

// File: tb/tb_ref_bank_scheduler.sv
// Directed bench for ref_bank_scheduler: bank loads, swaps, length errors,
// early frame ends and asynchronous reset, with a write scoreboard.
module tb_ref_bank_scheduler;

    logic        clk;
    logic        rst_n;
    logic [63:0] load_tdata;
    logic        load_tvalid, load_tlast, load_tready;
    logic        fft_tvalid, fft_tready, fft_tlast;
    logic        bram_we;
    logic [10:0] bram_waddr, bram_raddr;
    logic [63:0] bram_wdata;
    logic        active_bank, swap_pending, load_err;
    logic [15:0] frame_cnt;

    ref_bank_scheduler #(
        .BRAM_DEPTH_BITS (10),
        .C_DATA_WIDTH    (64),
        .FRAME_LEN       (1024)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .LOAD_TDATA     (load_tdata),
        .LOAD_TVALID    (load_tvalid),
        .LOAD_TLAST     (load_tlast),
        .LOAD_TREADY    (load_tready),
        .FFT_TVALID     (fft_tvalid),
        .FFT_TREADY     (fft_tready),
        .FFT_TLAST      (fft_tlast),
        .BRAM_WE        (bram_we),
        .BRAM_WADDR     (bram_waddr),
        .BRAM_WDATA     (bram_wdata),
        .BRAM_RADDR     (bram_raddr),
        .ACTIVE_BANK    (active_bank),
        .SWAP_PENDING   (swap_pending),
        .LOAD_ERR       (load_err),
        .FRAME_CNT      (frame_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: {bank, index, data} of every expected BRAM write
    logic [74:0] exp_q[$];
    int          wr_cnt = 0;

    always @(negedge clk) begin
        if (bram_we) begin
            logic [74:0] e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(bram_waddr), 64'h7ff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bram_waddr), 64'(e[74:64]));
                check("wr_data", bram_wdata, e[63:0]);
            end
        end
    end

    // driver state
    int          ld_idx = 0, ld_total = 0, ld_bad_acc = 0;
    logic        ld_bank = 1'b0;
    logic [63:0] ld_base = '0;
    bit          ld_hold = 1'b0;
    int          fft_left = 0, fft_pos = 0, fft_tlast_at = 1023;
    bit          fft_stall = 1'b0;

    task automatic drive();
        load_tvalid = ld_hold || (ld_idx < ld_total);
        load_tdata  = ld_base + 64'(ld_idx);
        load_tlast  = !ld_hold && (ld_idx < ld_total) && (ld_idx == ld_total - 1);
        fft_tvalid  = (fft_left > 0);
        fft_tready  = !fft_stall;
        fft_tlast   = (fft_left > 0) && (fft_pos == fft_tlast_at);
    endtask

    task automatic step();
        bit          ld_acc, fft_acc, fft_end;
        logic [9:0]  idx10;
        drive();
        ld_acc  = load_tvalid && load_tready;
        fft_acc = fft_tvalid && fft_tready;
        fft_end = fft_tlast || (fft_pos == 1023);
        @(posedge clk);
        #1;
        if (ld_acc) begin
            if (ld_hold) begin
                ld_bad_acc++;
            end else begin
                idx10 = ld_idx[9:0];
                if (ld_idx < 1024) exp_q.push_back({ld_bank, idx10, ld_base + 64'(ld_idx)});
                ld_idx++;
            end
        end
        if (fft_acc) begin
            fft_left--;
            fft_pos = fft_end ? 0 : fft_pos + 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_load(input int total, input logic bank, input logic [63:0] base);
        ld_idx = 0;
        ld_total = total;
        ld_bank = bank;
        ld_base = base;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tready"}, 64'(load_tready), 0);
        check({pfx, "_we"},     64'(bram_we), 0);
        check({pfx, "_waddr"},  64'(bram_waddr), 0);
        check({pfx, "_wdata"},  bram_wdata, 0);
        check({pfx, "_raddr"},  64'(bram_raddr), 0);
        check({pfx, "_active"}, 64'(active_bank), 0);
        check({pfx, "_pend"},   64'(swap_pending), 0);
        check({pfx, "_err"},    64'(load_err), 0);
        check({pfx, "_fcnt"},   64'(frame_cnt), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        drive();
        #12;
        check_reset("rst0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: four plain frames on bank 0
        fft_left = 4096;
        fft_pos = 0;
        bad = 0;
        for (int k = 0; k < 4096; k++) begin
            step();
            if (bram_raddr !== 11'(k % 1024)) bad++;
        end
        check("t1_raddr_seq_bad", 64'(bad), 0);
        check("t1_fcnt",   64'(frame_cnt), 4);
        check("t1_active", 64'(active_bank), 0);
        check("t1_pend",   64'(swap_pending), 0);
        check("t1_tready", 64'(load_tready), 1);

        // 2: load into bank 1 while a frame streams; swap at the boundary
        start_load(1024, 1'b1, 64'h0);
        run(10);
        fft_left = 1024;
        run(1014);
        check("t2_ld_done", 64'(ld_idx), 1024);
        check("t2_pend",    64'(swap_pending), 1);
        check("t2_active0", 64'(active_bank), 0);
        check("t2_tready0", 64'(load_tready), 0);
        run(9);
        check("t2_no_midswap", 64'(active_bank), 0);
        check("t2_pend_hold",  64'(swap_pending), 1);
        run(1);
        check("t2_active1", 64'(active_bank), 1);
        check("t2_pend_clr", 64'(swap_pending), 0);
        check("t2_fcnt",    64'(frame_cnt), 5);
        check("t2_tready1", 64'(load_tready), 1);
        run(1);
        check("t2_raddr_new", 64'(bram_raddr), 1024);
        check("t2_wr_cnt", 64'(wr_cnt), 1024);
        check("t2_sb_empty", 64'(exp_q.size()), 0);

        // 3: load into bank 0 while the reader idles at rptr 0
        start_load(1024, 1'b0, 64'h1000_0000_0000);
        run(1024);
        check("t3_pend",    64'(swap_pending), 1);
        check("t3_active1", 64'(active_bank), 1);
        run(1);
        check("t3_active0", 64'(active_bank), 0);
        check("t3_pend_clr", 64'(swap_pending), 0);
        check("t3_tready",  64'(load_tready), 1);

        // 4: short load then long load, both into bank 1
        start_load(100, 1'b1, 64'h2000_0000_0000);
        run(102);
        check("t4s_err",    64'(load_err), 1);
        check("t4s_pend",   64'(swap_pending), 0);
        check("t4s_active", 64'(active_bank), 0);
        check("t4s_wr_cnt", 64'(wr_cnt), 2148);
        start_load(1030, 1'b1, 64'h3000_0000_0000);
        run(1032);
        check("t4l_accepted", 64'(ld_idx), 1030);
        check("t4l_wr_cnt", 64'(wr_cnt), 3172);
        check("t4l_err",    64'(load_err), 1);
        check("t4l_pend",   64'(swap_pending), 0);
        check("t4l_active", 64'(active_bank), 0);
        check("t4l_tready", 64'(load_tready), 1);
        check("t4_sb_empty", 64'(exp_q.size()), 0);

        // 5: stall, early FFT_TLAST at rptr 500, then a held-off load
        fft_left = 501;
        fft_pos = 0;
        fft_tlast_at = 500;
        run(200);
        fft_stall = 1'b1;
        run(5);
        check("t5_stall_raddr", 64'(bram_raddr), 200);
        fft_stall = 1'b0;
        run(301);
        check("t5_raddr500", 64'(bram_raddr), 500);
        check("t5_fcnt",     64'(frame_cnt), 6);
        run(1);
        check("t5_rptr_wrap", 64'(bram_raddr), 0);
        fft_tlast_at = 1023;
        fft_pos = 0;
        fft_left = 2048;
        start_load(1024, 1'b1, 64'h4000_0000_0000);
        run(1024);
        check("t5_pend",    64'(swap_pending), 1);
        check("t5_no_swap", 64'(active_bank), 0);
        ld_hold = 1'b1;
        run(500);
        check("t5_hold_tready", 64'(load_tready), 0);
        check("t5_hold_acc",    64'(ld_bad_acc), 0);
        check("t5_hold_active", 64'(active_bank), 0);
        ld_hold = 1'b0;
        run(524);
        check("t5_active1", 64'(active_bank), 1);
        check("t5_pend_clr", 64'(swap_pending), 0);
        check("t5_fcnt2",   64'(frame_cnt), 8);
        check("t5_wr_cnt",  64'(wr_cnt), 4196);

        // 6: reset mid-load and mid-frame, then a fresh load into bank 1
        start_load(1024, 1'b0, 64'h5000_0000_0000);
        fft_left = 1024;
        fft_pos = 0;
        run(300);
        rst_n = 1'b0;
        #2;
        check_reset("rst1");
        exp_q.delete();
        start_load(0, 1'b0, 64'h0);
        fft_left = 0;
        fft_pos = 0;
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_load(1024, 1'b1, 64'h6000_0000_0000);
        begin
            int budget = 0;
            while (ld_idx < ld_total && budget < 1100) begin
                step();
                budget++;
            end
        end
        check("t6_ld_done", 64'(ld_idx), 1024);
        check("t6_pend",    64'(swap_pending), 1);
        check("t6_active0", 64'(active_bank), 0);
        step();
        check("t6_active1", 64'(active_bank), 1);
        check("t6_fcnt",    64'(frame_cnt), 0);
        check("t6_err",     64'(load_err), 0);
        step();
        check("end_sb_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
